// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   state_e        : FSM state encoding (also exported on the debug state output)
//   Op*/Fn*        : opcode and funct field constants
//   Alu*           : ALUControl codes
//   RegDst*/MemtoReg*/AluSrcB*/PcSrc* : datapath mux-select codes
package mips_mc_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11,
    StJal      = 4'd12,
    StJr       = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnJr  = 6'b001000;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  localparam logic [1:0] MemtoRegAlu  = 2'b00;
  localparam logic [1:0] MemtoRegData = 2'b01;
  localparam logic [1:0] MemtoRegPc   = 2'b10;

  localparam logic [1:0] AluSrcBReg   = 2'b00;
  localparam logic [1:0] AluSrcBFour  = 2'b01;
  localparam logic [1:0] AluSrcBImm   = 2'b10;
  localparam logic [1:0] AluSrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAluRes = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcReg    = 2'b11;

  // States that hold a memory request open until mem_rdy.
  function automatic logic is_wait_state(state_e s);
    return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Bundle between the multicycle control unit and its datapath/memory.
//   master : control unit (drives strobes/selects, receives IR fields, zero, mem_rdy)
//   slave  : datapath/memory side
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_rdy;
  logic       mem_req;
  logic       PCWrite;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUControl;
  logic       mem_err;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_rdy,
    output mem_req, PCWrite, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA,
           RegDst, MemtoReg, ALUSrcB, PCSrc, ALUControl, mem_err, state
  );

  modport slave (
    output opcode, funct, zero, mem_rdy,
    input  mem_req, PCWrite, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA,
           RegDst, MemtoReg, ALUSrcB, PCSrc, ALUControl, mem_err, state
  );
endinterface

// File: rtl/mips_alu_dec.sv
// R-type funct field to ALUControl decode (purely combinational).
//   i_funct       : Instr[5:0]
//   o_alu_control : ALU operation; unknown funct codes decode to add
module mips_alu_dec
  import mips_mc_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = AluAdd;
    unique case (i_funct)
      FnAdd:   o_alu_control = AluAdd;
      FnSub:   o_alu_control = AluSub;
      FnAnd:   o_alu_control = AluAnd;
      FnOr:    o_alu_control = AluOr;
      FnSlt:   o_alu_control = AluSlt;
      default: o_alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with memory wait states and timeout abort.
//   clk   : clock, rising edge
//   reset : synchronous active-low reset
//   bus   : master side of mips_mc_control_if (IR fields, zero, mem handshake,
//           datapath strobes/selects, mem_err pulse, debug state)
// TIMEOUT: consecutive mem_rdy-low cycles tolerated in a wait state (2..255).
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input logic                      clk,
  input logic                      reset,
  mips_mc_control_if.master        bus
);

  state_e     r_state;
  state_e     w_state_next;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_next;
  logic       w_wait;
  logic       w_timeout;
  logic [2:0] w_alu_funct;

  logic       w_mem_req, w_pc_write, w_iord, w_mem_write, w_ir_write, w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_src;
  logic [2:0] w_alu_control;

  mips_alu_dec u_alu_dec (
    .i_funct       (bus.funct),
    .o_alu_control (w_alu_funct)
  );

  assign w_wait    = is_wait_state(r_state);
  // Completion in the last tolerated cycle wins: timeout requires mem_rdy low.
  assign w_timeout = w_wait && !bus.mem_rdy && (r_wait_cnt == 8'(TIMEOUT - 1));

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= StFetch;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Next state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFetch: begin
        if (bus.mem_rdy) w_state_next = StDecode;
        else if (w_timeout) w_state_next = StFetch;
      end
      StDecode: begin
        case (bus.opcode)
          OpLw, OpSw: w_state_next = StMemAdr;
          OpRtype:    w_state_next = (bus.funct == FnJr) ? StJr : StExecute;
          OpBeq:      w_state_next = StBranch;
          OpAddi:     w_state_next = StAddiEx;
          OpJ:        w_state_next = StJump;
          OpJal:      w_state_next = StJal;
          default:    w_state_next = StFetch;
        endcase
      end
      StMemAdr:   w_state_next = (bus.opcode == OpLw) ? StMemRead : StMemWrite;
      StMemRead: begin
        if (bus.mem_rdy) w_state_next = StMemWb;
        else if (w_timeout) w_state_next = StFetch;
      end
      StMemWrite: begin
        if (bus.mem_rdy || w_timeout) w_state_next = StFetch;
      end
      StExecute:  w_state_next = StAluWb;
      StAddiEx:   w_state_next = StAddiWb;
      default:    w_state_next = StFetch;
    endcase
  end

  // Counter clears on any state change and on timeout (FETCH aborts back to itself).
  always_comb begin
    w_wait_cnt_next = r_wait_cnt;
    if ((w_state_next != r_state) || w_timeout) begin
      w_wait_cnt_next = '0;
    end else if (w_wait && !bus.mem_rdy) begin
      w_wait_cnt_next = r_wait_cnt + 8'd1;
    end
  end

  // Moore decode; wait-state strobes only fire on mem_rdy, and reset masks every strobe.
  always_comb begin
    w_mem_req     = 1'b0;
    w_pc_write    = 1'b0;
    w_iord        = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_reg_dst     = 2'b00;
    w_mem_to_reg  = 2'b00;
    w_alu_src_b   = 2'b00;
    w_pc_src      = 2'b00;
    w_alu_control = 3'b000;
    unique case (r_state)
      StFetch: begin
        w_mem_req     = 1'b1;
        w_alu_src_b   = AluSrcBFour;
        w_alu_control = AluAdd;
        w_pc_src      = PcSrcAluRes;
        w_ir_write    = bus.mem_rdy;
        w_pc_write    = bus.mem_rdy;
      end
      StDecode: begin
        w_alu_src_b   = AluSrcBImmSh;
        w_alu_control = AluAdd;
      end
      StMemAdr, StAddiEx: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = AluSrcBImm;
        w_alu_control = AluAdd;
      end
      StMemRead: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
      end
      StMemWb: begin
        w_reg_dst    = RegDstRt;
        w_mem_to_reg = MemtoRegData;
        w_reg_write  = 1'b1;
      end
      StMemWrite: begin
        w_mem_req   = 1'b1;
        w_iord      = 1'b1;
        w_mem_write = bus.mem_rdy;
      end
      StExecute: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = AluSrcBReg;
        w_alu_control = w_alu_funct;
      end
      StAluWb: begin
        w_reg_dst    = RegDstRd;
        w_mem_to_reg = MemtoRegAlu;
        w_reg_write  = 1'b1;
      end
      StBranch: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = AluSrcBReg;
        w_alu_control = AluSub;
        w_pc_src      = PcSrcAluOut;
        w_pc_write    = bus.zero;
      end
      StAddiWb: begin
        w_reg_dst    = RegDstRt;
        w_mem_to_reg = MemtoRegAlu;
        w_reg_write  = 1'b1;
      end
      StJump: begin
        w_pc_src   = PcSrcJump;
        w_pc_write = 1'b1;
      end
      StJal: begin
        w_pc_src     = PcSrcJump;
        w_pc_write   = 1'b1;
        w_reg_dst    = RegDstRa;
        w_mem_to_reg = MemtoRegPc;
        w_reg_write  = 1'b1;
      end
      StJr: begin
        w_pc_src   = PcSrcReg;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      w_mem_req   = 1'b0;
      w_pc_write  = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
    end
  end

  assign bus.mem_req    = w_mem_req;
  assign bus.PCWrite    = w_pc_write;
  assign bus.IorD       = w_iord;
  assign bus.MemWrite   = w_mem_write;
  assign bus.IRWrite    = w_ir_write;
  assign bus.RegWrite   = w_reg_write;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.RegDst     = w_reg_dst;
  assign bus.MemtoReg   = w_mem_to_reg;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.PCSrc      = w_pc_src;
  assign bus.ALUControl = w_alu_control;
  assign bus.mem_err    = w_timeout && reset;
  assign bus.state      = r_state;

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of consecutive mem_rdy-low cycles tolerated in a memory state before abort; legal range 2..255.
REQ-002 clk  in  1  sole clock; all state changes occur on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-004 opcode  in  6  Instr[31:26] from the instruction register.
REQ-005 funct  in  6  Instr[5:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_rdy  in  1  memory completion; the access is done in any cycle where mem_req=1 and mem_rdy=1.
REQ-008 mem_req  out  1  memory access request.
REQ-009 PCWrite, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA  out  1 each  datapath strobes and select lines.
REQ-010 RegDst, MemtoReg, ALUSrcB, PCSrc  out  2 each  mux selects: RegDst 00=rt, 01=rd, 10=$31; MemtoReg 00=ALUOut, 01=Data, 10=PC; PCSrc 00=ALUResult, 01=ALUOut, 10=jump target, 11=A (rs).
REQ-011 ALUControl  out  3  010=add, 110=sub, 000=and, 001=or, 111=slt.
REQ-012 mem_err  out  1  one-cycle pulse on memory timeout.
REQ-013 state  out  4  current FSM state, for debug only.

Function
REQ-014 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JAL and JR; outputs SHALL be a Moore decode of state, except that strobes are gated by mem_rdy as REQ-015 states.
REQ-015 FETCH, MEMREAD and MEMWRITE are wait states: they assert mem_req, hold state while mem_rdy=0, and assert PCWrite, IRWrite or MemWrite only in the cycle where mem_rdy=1.
REQ-016 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add and PCSrc=00; on mem_rdy it SHALL also drive IRWrite=1 and PCWrite=1, then move to DECODE.
REQ-017 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUControl=add (branch target into ALUOut), then branch on opcode: 100011 or 101011 go to MEMADR, 000000 goes to JR if funct=001000 and to EXECUTE otherwise, 000100 goes to BRANCH, 001000 goes to ADDIEX, 000010 goes to JUMP, 000011 goes to JAL, and any other opcode goes to FETCH with no write.
REQ-018 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10 and add, then go to MEMREAD for lw or MEMWRITE for sw; MEMREAD SHALL drive IorD=1 and go to MEMWB on mem_rdy; MEMWB SHALL drive RegDst=00, MemtoReg=01 and RegWrite=1; MEMWRITE SHALL drive IorD=1 and MemWrite=1 on mem_rdy, then go to FETCH.
REQ-019 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00 and the ALUControl decoded from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct decodes to add); ALUWB SHALL drive RegDst=01, MemtoReg=00 and RegWrite=1.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01 and PCWrite=zero.
REQ-021 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10 and add; ADDIWB SHALL drive RegDst=00, MemtoReg=00 and RegWrite=1.
REQ-022 JUMP SHALL drive PCSrc=10 and PCWrite=1; JAL SHALL drive PCSrc=10, PCWrite=1, RegDst=10, MemtoReg=10 and RegWrite=1, which links PC+4; JR SHALL drive PCSrc=11 and PCWrite=1.
REQ-023 MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, JAL and JR SHALL each last exactly one cycle and then go to FETCH.
REQ-024 With mem_rdy held high, instruction latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq, j, jal and jr 3 cycles.
REQ-025 An 8-bit wait counter SHALL clear on every state change and increment each wait-state cycle with mem_rdy=0; when it reaches TIMEOUT-1 with mem_rdy still 0, the block SHALL pulse mem_err for one cycle, suppress all strobes, and go to FETCH.
REQ-026 If mem_rdy rises in the same cycle the counter reaches TIMEOUT-1, the completion SHALL win and mem_err SHALL stay 0.
REQ-027 Select lines not named for a state SHALL be driven to 0; no state SHALL assert two of PCWrite, MemWrite and RegWrite except JAL, which asserts PCWrite and RegWrite.

Reset
REQ-028 While reset=0 at a clock edge, the block SHALL load state FETCH, clear the wait counter and clear mem_err.
REQ-029 While reset=0, mem_req, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0; this holds for reset asserted in any state, including mid-wait.
REQ-030 On the first edge after reset=1, the FSM SHALL start FETCH with the counter at 0.

Structure
REQ-031 Package mips_mc_pkg SHALL hold the state enum, the opcode/funct constants, the ALUControl codes and the mux-select codes.
REQ-032 Sub-module mips_alu_dec SHALL hold the combinational funct-to-ALUControl decode.

Verification
REQ-033 Test 1: lw with mem_rdy=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 only in cycle 5 with MemtoReg=01.
REQ-034 Test 2: jal, then add (funct 100000), then jr (funct 001000) -> JAL drives RegDst=10, MemtoReg=10, RegWrite=1, PCSrc=10; JR drives PCSrc=11, PCWrite=1; latencies are 3, 4 and 3 cycles.
REQ-035 Test 3: beq with zero=1, then with zero=0 -> PCWrite=1 in the first BRANCH cycle and 0 in the second, with PCSrc=01 in both.
REQ-036 Test 4: TIMEOUT=4, sw with mem_rdy=0 -> MemWrite is never 1, mem_err pulses once in the 4th wait cycle, and the next state is FETCH; repeat with mem_rdy rising in the 4th cycle -> MemWrite=1 and mem_err=0.
REQ-037 Test 5: reset=0 asserted during a MEMREAD wait -> on the next edge state=FETCH, all strobes are 0, mem_req=0 and the counter is 0.
REQ-038 Test 6: opcode 111111 -> DECODE returns to FETCH with no write strobe asserted.
